// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC generator with BTB lookup/update muxing and in-order prediction checking.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      btb_pc,
  input  logic             btb_hit,
  input  logic [31:0]      btb_target,
  output logic             btb_update,
  output logic             btb_taken,
  output logic [31:0]      btb_target_addr,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             mispredict,
  output logic [PTR_W:0]   fifo_count,
  output logic             err
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  logic [31:0]      r_fetch_pc;
  logic [32:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_err;
  logic             w_empty, w_mismatch, w_push, w_pop;
  logic [32:0]      w_head;
  assign w_empty         = r_count == '0;
  assign w_head          = r_fifo[r_head];
  // The BTB has a single pc port, so a resolution steals it and stalls fetch.
  assign btb_pc          = ex_valid ? ex_pc : r_fetch_pc;
  assign btb_update      = rst_n & ex_valid & ex_is_branch;
  assign btb_taken       = ex_valid & ex_taken;
  assign btb_target_addr = ex_valid ? ex_target : 32'h0;
  assign if_valid        = rst_n & ~ex_valid & (r_count != DEPTH_C);
  assign if_pc           = r_fetch_pc;
  assign if_pred_taken   = btb_hit;
  assign if_pred_target  = btb_hit ? btb_target : 32'h0;
  assign w_mismatch      = (ex_taken != w_head[32]) | (ex_taken & (ex_target != w_head[31:0]));
  assign mispredict      = rst_n & ex_valid & ~w_empty & w_mismatch;
  assign w_push          = if_valid & if_ready;
  assign w_pop           = ex_valid & ~w_empty;
  assign fifo_count      = r_count;
  assign err             = r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (mispredict) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
      end else if (w_pop) begin
        r_head  <= r_head + PTR_W'(1);
        r_count <= r_count - (PTR_W+1)'(1);
      end else if (w_push) begin
        r_fifo[r_tail] <= {if_pred_taken, if_pred_target};
        r_tail         <= r_tail + PTR_W'(1);
        r_count        <= r_count + (PTR_W+1)'(1);
        r_fetch_pc     <= btb_hit ? btb_target : r_fetch_pc + 32'd4;
      end
      if (ex_valid && w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: table-driven directed checks of fetch_pc_gen plus a reset-over-mispredict sequence.
module tb_fetch_pc_gen;
  logic        clk = 0;
  logic        rst_n;
  logic [31:0] btb_pc, btb_target, btb_target_addr, if_pc, if_pred_target, ex_pc, ex_target;
  logic        btb_hit, btb_update, btb_taken, if_valid, if_ready, if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_taken, mispredict, err;
  logic [2:0]  fifo_count;
  int          n_chk = 0, n_err = 0;

  fetch_pc_gen dut (
    .clk(clk), .rst_n(rst_n), .btb_pc(btb_pc), .btb_hit(btb_hit), .btb_target(btb_target),
    .btb_update(btb_update), .btb_taken(btb_taken), .btb_target_addr(btb_target_addr),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .mispredict(mispredict), .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit; logic [31:0] tgt; logic rdy; logic exv; logic [31:0] expc; logic br; logic tk; logic [31:0] extg;
    logic ivld; logic [31:0] ipc; logic ptk; logic [31:0] ptg; logic [31:0] bpc; logic upd; logic btk;
    logic [31:0] bta; logic misp; logic [2:0] cnt; logic e;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic hit, input logic [31:0] tgt, input logic rdy, input logic exv,
                       input logic [31:0] expc, input logic br, input logic tk, input logic [31:0] extg);
    btb_hit = hit; btb_target = tgt; if_ready = rdy; ex_valid = exv;
    ex_pc = expc; ex_is_branch = br; ex_taken = tk; ex_target = extg;
  endtask

  initial begin
    vecs[0]  = '{0,0,1,0,0,0,0,0,            1,32'h0,  0,0,32'h0,  0,0,0,0,0,0};
    vecs[1]  = '{0,0,1,0,0,0,0,0,            1,32'h4,  0,0,32'h4,  0,0,0,0,1,0};
    vecs[2]  = '{0,0,1,0,0,0,0,0,            1,32'h8,  0,0,32'h8,  0,0,0,0,2,0};
    vecs[3]  = '{0,0,1,0,0,0,0,0,            1,32'hc,  0,0,32'hc,  0,0,0,0,3,0};
    vecs[4]  = '{0,0,1,0,0,0,0,0,            0,32'h10, 0,0,32'h10, 0,0,0,0,4,0};
    vecs[5]  = '{0,0,1,1,32'h0,0,0,0,        0,32'h10, 0,0,32'h0,  0,0,0,0,4,0};
    vecs[6]  = '{0,0,1,1,32'h4,1,0,0,        0,32'h10, 0,0,32'h4,  1,0,0,0,3,0};
    vecs[7]  = '{0,0,1,1,32'h8,0,0,0,        0,32'h10, 0,0,32'h8,  0,0,0,0,2,0};
    vecs[8]  = '{0,0,1,1,32'hc,0,0,0,        0,32'h10, 0,0,32'hc,  0,0,0,0,1,0};
    vecs[9]  = '{1,32'h100,1,0,0,0,0,0,      1,32'h10, 1,32'h100,32'h10, 0,0,0,0,0,0};
    vecs[10] = '{0,0,1,1,32'h10,1,1,32'h100, 0,32'h100,0,0,32'h10, 1,1,32'h100,0,1,0};
    vecs[11] = '{0,0,1,0,0,0,0,0,            1,32'h100,0,0,32'h100,0,0,0,0,0,0};
    vecs[12] = '{0,0,1,1,32'h100,1,1,32'h40, 0,32'h104,0,0,32'h100,1,1,32'h40,1,1,0};
    vecs[13] = '{1,32'h200,1,0,0,0,0,0,      1,32'h40, 1,32'h200,32'h40, 0,0,0,0,0,0};
    vecs[14] = '{0,0,1,1,32'h40,1,1,32'h300, 0,32'h200,0,0,32'h40, 1,1,32'h300,1,1,0};
    vecs[15] = '{1,32'h500,1,0,0,0,0,0,      1,32'h300,1,32'h500,32'h300,0,0,0,0,0,0};
    vecs[16] = '{0,0,1,1,32'h300,1,0,0,      0,32'h500,0,0,32'h300,1,0,0,1,1,0};
    vecs[17] = '{0,0,1,0,0,0,0,0,            1,32'h304,0,0,32'h304,0,0,0,0,0,0};
    vecs[18] = '{0,0,0,0,0,0,0,0,            1,32'h308,0,0,32'h308,0,0,0,0,1,0};
    vecs[19] = '{0,0,0,0,0,0,0,0,            1,32'h308,0,0,32'h308,0,0,0,0,1,0};
    vecs[20] = '{0,0,0,1,32'h304,0,0,0,      0,32'h308,0,0,32'h304,0,0,0,0,1,0};
    vecs[21] = '{0,0,0,0,0,0,0,0,            1,32'h308,0,0,32'h308,0,0,0,0,0,0};
    vecs[22] = '{0,0,0,1,32'h50,1,1,32'h60,  0,32'h308,0,0,32'h50, 1,1,32'h60,0,0,0};
    vecs[23] = '{0,0,0,0,0,0,0,0,            1,32'h308,0,0,32'h308,0,0,0,0,0,1};
    rst_n = 0;
    drive(1, 32'h80, 1, 1, 32'h4, 1, 1, 32'h8);
    @(posedge clk); #1;
    chk("rst if_valid", {31'h0, if_valid}, 0);
    chk("rst btb_update", {31'h0, btb_update}, 0);
    chk("rst mispredict", {31'h0, mispredict}, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].hit, vecs[i].tgt, vecs[i].rdy, vecs[i].exv, vecs[i].expc, vecs[i].br, vecs[i].tk, vecs[i].extg);
      #1;
      chk($sformatf("v%0d if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].ivld});
      chk($sformatf("v%0d if_pc", i), if_pc, vecs[i].ipc);
      chk($sformatf("v%0d if_pred_taken", i), {31'h0, if_pred_taken}, {31'h0, vecs[i].ptk});
      chk($sformatf("v%0d if_pred_target", i), if_pred_target, vecs[i].ptg);
      chk($sformatf("v%0d btb_pc", i), btb_pc, vecs[i].bpc);
      chk($sformatf("v%0d btb_update", i), {31'h0, btb_update}, {31'h0, vecs[i].upd});
      chk($sformatf("v%0d btb_taken", i), {31'h0, btb_taken}, {31'h0, vecs[i].btk});
      chk($sformatf("v%0d btb_target_addr", i), btb_target_addr, vecs[i].bta);
      chk($sformatf("v%0d mispredict", i), {31'h0, mispredict}, {31'h0, vecs[i].misp});
      chk($sformatf("v%0d fifo_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].cnt});
      chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vecs[i].e});
      @(posedge clk); #1;
    end
    drive(1, 32'h700, 1, 0, 0, 0, 0, 0);
    #1;
    chk("seq push if_pc", if_pc, 32'h308);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 32'h308, 1, 0, 0);
    #1;
    chk("seq pre-rst mispredict", {31'h0, mispredict}, 1);
    chk("seq pre-rst if_pc", if_pc, 32'h700);
    rst_n = 0;
    #1;
    chk("seq rst mispredict", {31'h0, mispredict}, 0);
    chk("seq rst btb_update", {31'h0, btb_update}, 0);
    chk("seq rst if_valid", {31'h0, if_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("seq post-rst if_pc", if_pc, 32'h0);
    chk("seq post-rst fifo_count", {29'h0, fifo_count}, 0);
    chk("seq post-rst err", {31'h0, err}, 0);
    chk("seq post-rst if_valid", {31'h0, if_valid}, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage next-PC generator. It owns the fetch PC, looks it up in the combinational BTB each cycle, and issues PC+prediction to the fetch/decode stage over a valid/ready handshake.
- It keeps an in-order FIFO of issued predictions and checks each one against execute-stage resolution.
- On a mispredict it flushes and redirects. It also drives the BTB update port, multiplexing the BTB pc input between lookup and update.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset
FIFO_DEPTH, 4, in-flight prediction entries (power of 2, >=2)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
btb_pc  out  32  pc driven to BTB (lookup or update address)
btb_hit  in  1  BTB hit for btb_pc (combinational, same cycle)
btb_target  in  32  BTB predicted target
btb_update  out  1  BTB update strobe
btb_taken  out  1  resolved direction to BTB
btb_target_addr  out  32  resolved target to BTB
if_valid  out  1  fetch request valid
if_ready  in  1  fetch/decode accepts request
if_pc  out  32  issued PC
if_pred_taken  out  1  predicted taken
if_pred_target  out  32  predicted target (0 when not taken)
ex_valid  in  1  one instruction resolved (program order)
ex_pc  in  32  resolved instruction PC
ex_is_branch  in  1  resolved instruction is a branch/jump
ex_taken  in  1  actual direction
ex_target  in  32  actual target
mispredict  out  1  comb. pulse: resolution disagrees with prediction
fifo_count  out  PTR_W+1  occupancy
err  out  1  sticky: ex_valid with empty FIFO

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, FIFO empty (count 0, pointers 0), err=0. While rst_n=0, if_valid=0, btb_update=0 and mispredict=0 regardless of inputs.
- Resolve cycle (ex_valid=1):
  - btb_pc=ex_pc.
  - btb_update=ex_is_branch; btb_taken=ex_taken; btb_target_addr=ex_target.
  - if_valid=0 (the BTB port is busy, so fetch stalls).
- Fetch cycle (ex_valid=0):
  - btb_pc=fetch_pc; btb_update=0; btb_taken=0; btb_target_addr=0.
  - if_valid=(count<FIFO_DEPTH); if_pc=fetch_pc.
  - if_pred_taken=btb_hit; if_pred_target=btb_hit?btb_target:0.
- Accept (if_valid&&if_ready): push {if_pred_taken,if_pred_target} to the FIFO tail. fetch_pc <= btb_hit ? btb_target : fetch_pc+4 (32-bit wrap, no carry out). With if_valid=1 and if_ready=0, fetch_pc and the if_* outputs hold stable.
- FIFO full (count==FIFO_DEPTH): if_valid=0 until a pop.
- Pop: ex_valid=1 with count>0 pops the head, latency 0.
  - Mismatch = (ex_taken!=head.pred_taken) or (ex_taken && ex_target!=head.pred_target).
  - Non-branch resolutions use ex_taken=0.
- mispredict=ex_valid&&count>0&&mismatch.
- On mispredict, at the same edge:
  - FIFO flushed (count=0, ptrs=0).
  - fetch_pc <= ex_taken ? ex_target : ex_pc+4.
- No mispredict on pop: count-1, fetch_pc unchanged.
- Push and pop never coincide, because a resolve cycle blocks fetch.
- ex_valid with count==0: no pop, no redirect, err<=1 (sticky until reset). The BTB update still occurs.
- Reset mid-operation overrides all events at that edge, including a pending mispredict.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Reset, BTB always misses, if_ready=1, no ex_valid -> if_pc 0,4,8,12 on consecutive cycles; fifo_count 1..4; if_valid=0 once count=4.
2. btb_hit=1, btb_target=0x100 at pc 0x8 -> next if_pc=0x100; FIFO entry {1,0x100}; ex_valid with ex_taken=1, ex_target=0x100 -> mispredict=0, count-1.
3. Predicted not-taken at 0x4, then ex_valid ex_pc=0x4, ex_taken=1, ex_target=0x40 -> mispredict=1, btb_pc=0x4, btb_update=1, btb_target_addr=0x40; next cycle count=0, if_pc=0x40.
4. Predicted taken to 0x200, resolved taken to 0x300 -> mispredict=1, redirect to 0x300. Predicted taken, resolved not-taken at ex_pc=0x10 -> redirect to 0x14.
5. if_ready=0 for 3 cycles, then ex_valid asserted mid-stall -> if_pc stable during the stall, if_valid=0 in the resolve cycle, btb_pc=ex_pc in that cycle.
6. ex_valid at count=0 -> err=1 and stays 1 afterwards, fetch_pc unchanged. rst_n=0 during a mispredict cycle -> fetch_pc=RESET_PC, err=0.
